// File: rtl/imem_responder.sv
// imem_responder: word-organised instruction/data store behind a valid/ready
// request channel and a valid/ready response channel. One request is in
// flight at a time; the response appears LATENCY cycles after acceptance.
module imem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h01000000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   // One past the last byte of the array; 33 bits so the top end cannot wrap.
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;

   logic              accept;
   logic              exec;

   logic [31:0]       lat_addr;
   logic              lat_write;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_wstrb;

   logic [31:0]       acc_addr;
   logic              acc_write;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_wstrb;
   logic              acc_err;
   logic [IDX_W-1:0]  acc_idx;

   logic [31:0]       rdata_q;
   logic              error_q;

   logic [31:0]       mem [DEPTH_WORDS];

   // Misaligned, below the base, or past the end of the array.
   function automatic logic addr_error(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= END_ADDR);
   endfunction

   // Word index from the byte offset; only meaningful when addr_error is 0.
   function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   // Next-state, handshake and access-strobe decode.
   always_comb begin
      req_ready = (state_q == IDLE) && reset;
      accept    = req_valid && req_ready;
      state_d   = state_q;
      cnt_d     = cnt_q;
      exec      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
                  exec    = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               cnt_d   = 4'd0;
               // A reset landing on this edge abandons the access entirely.
               exec    = reset;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Access operands: live request when executing straight from IDLE
   // (single-cycle latency), otherwise the copy latched at acceptance.
   always_comb begin
      if (state_q == IDLE) begin
         acc_addr  = req_addr;
         acc_write = req_write;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end else begin
         acc_addr  = lat_addr;
         acc_write = lat_write;
         acc_wdata = lat_wdata;
         acc_wstrb = lat_wstrb;
      end
      acc_err = addr_error(acc_addr);
      acc_idx = word_index(acc_addr);
   end

   // FSM state and latency counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the request on acceptance; data only, no reset needed.
   always_ff @(posedge clock) begin
      if (accept) begin
         lat_addr  <= req_addr;
         lat_write <= req_write;
         lat_wdata <= req_wdata;
         lat_wstrb <= req_wstrb;
      end
   end

   // Byte-enabled write into the array, once, as the response is formed.
   always_ff @(posedge clock) begin
      if (exec && !acc_err && acc_write) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wstrb[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

   // Response payload: loaded on execution, held through backpressure,
   // cleared once the consumer takes it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata_q <= '0;
         error_q <= 1'b0;
      end else if (exec) begin
         error_q <= acc_err;
         rdata_q <= (acc_err || acc_write) ? 32'h0 : mem[acc_idx];
      end else if ((state_q == RESP) && rsp_ready) begin
         rdata_q <= '0;
         error_q <= 1'b0;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_error = error_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed vector table, multi-cycle corner
// sequences, and random traffic against a word-array reference model.
module tb_imem_responder;

   localparam logic [31:0] BASE  = 32'h01000000;
   localparam int          DEPTH = 1024;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // LATENCY=2 instance
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   // LATENCY=4 instance
   logic        d4_reset;
   logic        d4_req_valid;
   logic        d4_req_ready;
   logic [31:0] d4_req_addr;
   logic        d4_req_write;
   logic [31:0] d4_req_wdata;
   logic [3:0]  d4_req_wstrb;
   logic        d4_rsp_valid;
   logic        d4_rsp_ready;
   logic [31:0] d4_rsp_rdata;
   logic        d4_rsp_error;

   imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error)
   );

   imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (
      .clock(clock), .reset(d4_reset),
      .req_valid(d4_req_valid), .req_ready(d4_req_ready), .req_addr(d4_req_addr),
      .req_write(d4_req_write), .req_wdata(d4_req_wdata), .req_wstrb(d4_req_wstrb),
      .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_rdata(d4_rsp_rdata),
      .rsp_error(d4_rsp_error)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Reference model: plain word array plus the address rules.
   logic [31:0] model_mem [DEPTH];

   function automatic bit spec_err(input logic [31:0] a);
      if (a % 4 != 0) return 1'b1;
      if (a < BASE) return 1'b1;
      if ((a - BASE) / 4 >= DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_apply(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [3:0] ws, output logic [31:0] erd, output logic eer);
      int idx;
      if (spec_err(a)) begin
         erd = 32'h0;
         eer = 1'b1;
      end else begin
         idx = int'((a - BASE) / 4);
         eer = 1'b0;
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (ws[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
            erd = 32'h0;
         end else begin
            erd = model_mem[idx];
         end
      end
   endtask

   // One full transaction on the LATENCY=2 instance, entered and left at a
   // falling edge. hold>0 keeps rsp_ready low for that many extra cycles
   // while a stray request is presented.
   task automatic xact(input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] ws, input int hold,
                       input logic [31:0] exp_rd, input logic exp_er);
      int n;
      int lat;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) check({tag, "_ready_wait"}, req_ready, 1);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      req_wdata = wd;
      req_wstrb = ws;
      rsp_ready = (hold == 0);
      @(negedge clock);
      req_valid = 1'b0;
      req_addr  = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 50) begin
         @(negedge clock);
         lat++;
      end
      check({tag, "_latency"}, lat, 2);
      check({tag, "_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_error"}, rsp_error, exp_er);
      if (hold > 0) begin
         req_valid = 1'b1;
         req_addr  = BASE;
         req_write = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, "_bp_valid"}, rsp_valid, 1);
            check({tag, "_bp_rdata"}, rsp_rdata, exp_rd);
            check({tag, "_bp_error"}, rsp_error, exp_er);
            check({tag, "_bp_req_ready"}, req_ready, 0);
         end
         rsp_ready = 1'b1;
      end
      @(negedge clock);
      req_valid = 1'b0;
      check({tag, "_done_valid"}, rsp_valid, 0);
      check({tag, "_done_req_ready"}, req_ready, 1);
      check({tag, "_done_rdata"}, rsp_rdata, 0);
   endtask

   // Transaction on the LATENCY=4 instance.
   task automatic d4_xact(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
      int lat;
      check({tag, "_req_ready"}, d4_req_ready, 1);
      d4_req_valid = 1'b1;
      d4_req_addr  = a;
      d4_req_write = w;
      d4_req_wdata = wd;
      d4_req_wstrb = 4'hF;
      @(negedge clock);
      d4_req_valid = 1'b0;
      lat = 1;
      while (!d4_rsp_valid && lat < 50) begin
         @(negedge clock);
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_rdata"}, d4_rsp_rdata, exp_rd);
      check({tag, "_error"}, d4_rsp_error, 0);
      @(negedge clock);
      check({tag, "_done_valid"}, d4_rsp_valid, 0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic        w;
      logic [31:0] wd;
      logic [3:0]  ws;
      int          hold;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [31:0] erd;
      logic        eer;
      logic [31:0] a;
      logic        w;
      logic [31:0] wd;
      logic [3:0]  ws;
      int          k;
      int          hold;

      tbl.push_back('{32'h01000010, 1'b1, 32'hDEADBEEF, 4'hF,    0, 32'h0,        1'b0});
      tbl.push_back('{32'h01000010, 1'b0, 32'h0,        4'h0,    0, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{32'h01000010, 1'b1, 32'h11223344, 4'b0101, 0, 32'h0,        1'b0});
      tbl.push_back('{32'h01000010, 1'b0, 32'h0,        4'h0,    0, 32'hDE22BE44, 1'b0});
      tbl.push_back('{32'h01000002, 1'b0, 32'h0,        4'h0,    0, 32'h0,        1'b1});
      tbl.push_back('{32'h00FFFFFC, 1'b0, 32'h0,        4'h0,    0, 32'h0,        1'b1});
      tbl.push_back('{32'h01000000, 1'b1, 32'hA5A5A5A5, 4'hF,    0, 32'h0,        1'b0});
      tbl.push_back('{32'h01001000, 1'b1, 32'hFFFFFFFF, 4'hF,    0, 32'h0,        1'b1});
      tbl.push_back('{32'h01000000, 1'b0, 32'h0,        4'h0,    5, 32'hA5A5A5A5, 1'b0});
      tbl.push_back('{32'h01000010, 1'b1, 32'h0,        4'h0,    1, 32'h0,        1'b0});
      tbl.push_back('{32'h01000010, 1'b0, 32'h0,        4'h0,    0, 32'hDE22BE44, 1'b0});
      tbl.push_back('{32'h01000FFC, 1'b1, 32'h12345678, 4'hF,    0, 32'h0,        1'b0});
      tbl.push_back('{32'h01000FFC, 1'b0, 32'h0,        4'h0,    2, 32'h12345678, 1'b0});
      tbl.push_back('{32'h01000011, 1'b1, 32'h0BADF00D, 4'hF,    0, 32'h0,        1'b1});
      tbl.push_back('{32'hFFFFFFFC, 1'b0, 32'h0,        4'h0,    0, 32'h0,        1'b1});

      reset        = 1'b0;
      req_valid    = 1'b1;
      req_addr     = BASE;
      req_write    = 1'b0;
      req_wdata    = 32'h0;
      req_wstrb    = 4'h0;
      rsp_ready    = 1'b1;
      d4_reset     = 1'b0;
      d4_req_valid = 1'b0;
      d4_req_addr  = BASE;
      d4_req_write = 1'b0;
      d4_req_wdata = 32'h0;
      d4_req_wstrb = 4'h0;
      d4_rsp_ready = 1'b1;

      // Reset held with a request pending: nothing accepted, nothing returned.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_rdata", rsp_rdata, 0);
         check("rst_rsp_error", rsp_error, 0);
      end
      req_valid = 1'b0;
      reset     = 1'b1;
      d4_reset  = 1'b1;
      #1;
      check("rst_release_req_ready", req_ready, 1);
      @(negedge clock);

      // Directed vectors.
      for (int i = 0; i < tbl.size(); i++) begin
         model_apply(tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].ws, erd, eer);
         xact($sformatf("vec%0d", i), tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].ws,
              tbl[i].hold, tbl[i].rd, tbl[i].er);
      end

      // LATENCY=4: committed write, then a write abandoned by reset in WAIT.
      d4_xact("d4_wr", 32'h01000020, 1'b1, 32'hCAFEF00D, 32'h0);
      d4_xact("d4_rd", 32'h01000020, 1'b0, 32'h0, 32'hCAFEF00D);
      check("d4_pre_req_ready", d4_req_ready, 1);
      d4_req_valid = 1'b1;
      d4_req_addr  = 32'h01000020;
      d4_req_write = 1'b1;
      d4_req_wdata = 32'h0BADC0DE;
      d4_req_wstrb = 4'hF;
      @(negedge clock);
      d4_req_valid = 1'b0;
      check("d4_wait_req_ready", d4_req_ready, 0);
      @(negedge clock);
      d4_reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check("d4_rst_rsp_valid", d4_rsp_valid, 0);
         check("d4_rst_req_ready", d4_req_ready, 0);
      end
      d4_reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("d4_abandon_rsp_valid", d4_rsp_valid, 0);
         @(negedge clock);
      end
      d4_xact("d4_rd_after", 32'h01000020, 1'b0, 32'h0, 32'hCAFEF00D);

      // Random traffic over a small preloaded window plus error addresses.
      for (int i = 0; i < 16; i++) begin
         a  = BASE + 32'(4 * i);
         wd = $urandom;
         model_apply(a, 1'b1, wd, 4'hF, erd, eer);
         xact($sformatf("init%0d", i), a, 1'b1, wd, 4'hF, 0, erd, eer);
      end
      for (int i = 0; i < 150; i++) begin
         k = $urandom_range(0, 99);
         if (k < 70)
            a = BASE + 32'(4 * $urandom_range(0, 15));
         else if (k < 80)
            a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
         else if (k < 90)
            a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
         else
            a = $urandom_range(0, 32'h00FFFFFF) & 32'hFFFFFFFC;
         w    = 1'($urandom_range(0, 1));
         wd   = $urandom;
         ws   = 4'($urandom_range(0, 15));
         hold = $urandom_range(0, 2);
         model_apply(a, w, wd, ws, erd, eer);
         xact($sformatf("rnd%0d", i), a, w, wd, ws, hold, erd, eer);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
